// File: rtl/tx_gearbox_mux_if.sv
// Word-in / lane-slice-out bus of the transmit gearbox.
// The master is the word source and slice sink; the slave is the gearbox.
interface tx_gearbox_mux_if #(
  parameter int Nin  = 16,
  parameter int Nout = 4
);
  logic [Nin-1:0]  din;
  logic            din_valid;
  logic            din_ready;
  logic [Nout-1:0] dout_p;
  logic [Nout-1:0] dout_n;
  logic            dout_valid;

  modport master (
    output din, din_valid,
    input  din_ready, dout_p, dout_n, dout_valid
  );

  modport slave (
    input  din, din_valid,
    output din_ready, dout_p, dout_n, dout_valid
  );
endinterface

// File: rtl/tx_gearbox_mux.sv
// Nin:Nout transmit gearbox: word FIFO, PRBS7/pattern/idle sources,
// word-boundary mode switching and a registered differential lane output.
module tx_gearbox_mux #(
  parameter int Nin   = 16,
  parameter int Nout  = 4,
  parameter int Depth = 4
) (
  input  logic                     clk,
  input  logic                     rstb,
  input  logic                     en,
  input  logic [1:0]               mode,
  input  logic                     inv_pol,
  input  logic [Nin-1:0]           pat,
  tx_gearbox_mux_if.slave          bus,
  output logic [$clog2(Depth):0]   fifo_level,
  output logic [7:0]               underflow_cnt
);

  localparam int R     = Nin / Nout;
  localparam int CNT_W = (R > 1) ? $clog2(R) : 1;
  localparam int PTR_W = $clog2(Depth);
  localparam int LVL_W = PTR_W + 1;

  typedef enum logic [1:0] {
    MODE_DATA = 2'd0,
    MODE_PRBS = 2'd1,
    MODE_PAT  = 2'd2,
    MODE_IDLE = 2'd3
  } mode_e;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [Nin-1:0]   sr_q, sr_d;
  mode_e            mode_q, mode_d;
  logic [6:0]       prbs_q, prbs_d;
  logic [7:0]       uf_q, uf_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic [Nout-1:0]  dout_p_q, dout_p_d;
  logic [Nout-1:0]  dout_n_q, dout_n_d;
  logic             dout_valid_q, dout_valid_d;
  logic [Nin-1:0]   mem_q [Depth];

  logic             push, pop, din_ready;
  logic [Nin-1:0]   word;
  logic [Nout-1:0]  slice;
  logic [6:0]       prbs_s;
  logic [Nin-1:0]   prbs_word;

  assign din_ready      = (level_q != LVL_W'(Depth));
  assign push           = bus.din_valid & din_ready;
  assign bus.din_ready  = din_ready;
  assign bus.dout_p     = dout_p_q;
  assign bus.dout_n     = dout_n_q;
  assign bus.dout_valid = dout_valid_q;
  assign fifo_level     = level_q;
  assign underflow_cnt  = uf_q;

  // Next Nin LFSR outputs, LSB first; a stuck-at-zero state is reseeded.
  always_comb begin
    prbs_s    = (prbs_q == 7'd0) ? 7'h7F : prbs_q;
    prbs_word = '0;
    for (int i = 0; i < Nin; i++) begin
      prbs_word[i] = prbs_s[6] ^ prbs_s[5];
      prbs_s       = {prbs_s[5:0], prbs_word[i]};
    end
  end

  // NOTE: every variable gets a default at the top so no path leaves one unassigned (no latches).
  always_comb begin
    cnt_d        = cnt_q;
    sr_d         = sr_q;
    mode_d       = mode_q;
    prbs_d       = prbs_q;
    uf_d         = uf_q;
    rd_ptr_d     = rd_ptr_q;
    dout_p_d     = '0;
    dout_n_d     = '0;
    dout_valid_d = 1'b0;
    pop          = 1'b0;
    word         = '0;
    slice        = '0;

    if (en) begin
      if (cnt_q == '0) begin
        mode_d = mode_e'(mode);
        unique case (mode_e'(mode))
          MODE_DATA: begin
            if (level_q != '0) begin
              word     = mem_q[rd_ptr_q];
              pop      = 1'b1;
              rd_ptr_d = rd_ptr_q + 1'b1;
            end else if (uf_q != 8'hFF) begin
              uf_d = uf_q + 8'd1;
            end
          end
          MODE_PRBS: begin
            word   = prbs_word;
            prbs_d = prbs_s;
          end
          MODE_PAT:  word = pat;
          MODE_IDLE: word = '0;
        endcase
        slice = word[Nout-1:0];
        sr_d  = word >> Nout;
      end else begin
        slice = (mode_q == MODE_IDLE) ? '0 : sr_q[Nout-1:0];
        sr_d  = sr_q >> Nout;
      end
      cnt_d        = (cnt_q == CNT_W'(R - 1)) ? '0 : cnt_q + 1'b1;
      dout_p_d     = slice ^ {Nout{inv_pol}};
      dout_n_d     = ~(slice ^ {Nout{inv_pol}});
      dout_valid_d = 1'b1;
    end else begin
      cnt_d = '0;
    end
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    level_d  = level_q + LVL_W'(push) - LVL_W'(pop);
  end

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      cnt_q        <= '0;
      sr_q         <= '0;
      mode_q       <= MODE_IDLE;
      prbs_q       <= 7'h7F;
      uf_q         <= '0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      level_q      <= '0;
      dout_p_q     <= '0;
      dout_n_q     <= '0;
      dout_valid_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      sr_q         <= sr_d;
      mode_q       <= mode_d;
      prbs_q       <= prbs_d;
      uf_q         <= uf_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      level_q      <= level_d;
      dout_p_q     <= dout_p_d;
      dout_n_q     <= dout_n_d;
      dout_valid_q <= dout_valid_d;
    end
  end

  // NOTE: the storage array has no reset; pointers and level alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= bus.din;
  end

endmodule

// File: tb/tb_tx_gearbox_mux.sv
// Randomised and directed bench for tx_gearbox_mux against a queue-based
// word model and a golden 127-bit PRBS7 sequence.
module tb_tx_gearbox_mux;
  localparam int NIN   = 16;
  localparam int NOUT  = 4;
  localparam int DEPTH = 4;
  localparam int R     = NIN / NOUT;

  logic             clk;
  logic             rstb;
  logic             en;
  logic [1:0]       mode;
  logic             inv_pol;
  logic [NIN-1:0]   pat;
  logic [2:0]       fifo_level;
  logic [7:0]       underflow_cnt;

  tx_gearbox_mux_if #(.Nin(NIN), .Nout(NOUT)) bus_if ();

  tx_gearbox_mux #(.Nin(NIN), .Nout(NOUT), .Depth(DEPTH)) dut (
    .clk           (clk),
    .rstb          (rstb),
    .en            (en),
    .mode          (mode),
    .inv_pol       (inv_pol),
    .pat           (pat),
    .bus           (bus_if.slave),
    .fifo_level    (fifo_level),
    .underflow_cnt (underflow_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: FIFO as a queue, PRBS as an index into one period of the sequence.
  bit             prbs_seq [127];
  logic [NIN-1:0] fifo_m [$];
  logic [NIN-1:0] word_m;
  int             pos_m;
  int             uf_m;
  int             pidx_m;
  logic [NOUT-1:0] exp_p, exp_n;
  logic            exp_v;

  task automatic model_reset();
    fifo_m.delete();
    word_m = '0;
    pos_m  = 0;
    uf_m   = 0;
    pidx_m = 0;
    exp_p  = '0;
    exp_n  = '0;
    exp_v  = 1'b0;
  endtask

  task automatic model_edge();
    bit             push_m;
    logic [NOUT-1:0] sl;
    push_m = bus_if.din_valid && (fifo_m.size() < DEPTH);
    if (en) begin
      if (pos_m == 0) begin
        case (mode)
          2'd0: begin
            if (fifo_m.size() > 0) word_m = fifo_m.pop_front();
            else begin
              word_m = '0;
              if (uf_m < 255) uf_m++;
            end
          end
          2'd1: begin
            for (int i = 0; i < NIN; i++) word_m[i] = prbs_seq[(pidx_m + i) % 127];
            pidx_m = (pidx_m + NIN) % 127;
          end
          2'd2: word_m = pat;
          default: word_m = '0;
        endcase
      end
      sl    = word_m[pos_m*NOUT +: NOUT];
      exp_p = sl ^ {NOUT{inv_pol}};
      exp_n = ~exp_p;
      exp_v = 1'b1;
      pos_m = (pos_m + 1) % R;
    end else begin
      pos_m = 0;
      exp_p = '0;
      exp_n = '0;
      exp_v = 1'b0;
    end
    if (push_m) fifo_m.push_back(bus_if.din);
  endtask

  task automatic compare_all();
    check("dout_p", 32'(bus_if.dout_p), 32'(exp_p));
    check("dout_n", 32'(bus_if.dout_n), 32'(exp_n));
    check("dout_valid", 32'(bus_if.dout_valid), 32'(exp_v));
    check("fifo_level", 32'(fifo_level), 32'(fifo_m.size()));
    check("din_ready", 32'(bus_if.din_ready), 32'(fifo_m.size() != DEPTH));
    check("underflow_cnt", 32'(underflow_cnt), 32'(uf_m));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    rstb             = 1'b0;
    en               = 1'b0;
    mode             = 2'd3;
    inv_pol          = 1'b0;
    bus_if.din_valid = 1'b0;
    #1;
    model_reset();
    compare_all();
    #2;
    rstb = 1'b1;
  endtask

  logic [NOUT-1:0] t1_p [R];
  logic [NOUT-1:0] t1_n [R];
  bit              bits [256];
  logic [6:0]      first7;
  int              mism;

  initial begin
    logic [6:0] s;
    s = 7'h7F;
    for (int i = 0; i < 127; i++) begin
      prbs_seq[i] = s[6] ^ s[5];
      s = {s[5:0], prbs_seq[i]};
    end

    pat        = 16'hA5A5;
    bus_if.din = '0;
    #2;
    do_reset();
    #5;

    // Single word 4321 emerges as slices 1,2,3,4.
    bus_if.din = 16'h4321; bus_if.din_valid = 1'b1;
    step();
    bus_if.din_valid = 1'b0;
    en = 1'b1; mode = 2'd0;
    for (int i = 0; i < R; i++) begin
      step();
      t1_p[i] = bus_if.dout_p;
      t1_n[i] = bus_if.dout_n;
    end
    check("t1_p0", 32'(t1_p[0]), 32'h1);
    check("t1_p3", 32'(t1_p[3]), 32'h4);
    check("t1_n0", 32'(t1_n[0]), 32'hE);
    check("t1_n3", 32'(t1_n[3]), 32'hB);

    // Back-to-back pushes while disabled: fourth fills, fifth is refused.
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus_if.din = NIN'($urandom); bus_if.din_valid = 1'b1;
      if (i == 4) check("t2_ready_full", 32'(bus_if.din_ready), 32'h0);
      step();
    end
    check("t2_level", 32'(fifo_level), 32'h4);
    bus_if.din_valid = 1'b0;
    en = 1'b1;
    repeat (20) step();

    // Empty FIFO in data mode: zeros and a saturating underflow count.
    do_reset();
    mode = 2'd0; en = 1'b1;
    repeat (8) step();
    check("t3_uf2", 32'(underflow_cnt), 32'd2);
    check("t3_zero", 32'(bus_if.dout_p), 32'h0);
    repeat (1200) step();
    check("t3_uf_sat", 32'(underflow_cnt), 32'd255);

    // PRBS7 from the 7F seed and its 127-bit period.
    do_reset();
    mode = 2'd1; en = 1'b1;
    for (int k = 0; k < 64; k++) begin
      step();
      for (int j = 0; j < NOUT; j++) bits[k*NOUT + j] = bus_if.dout_p[j];
    end
    for (int i = 0; i < 7; i++) first7[i] = bits[i];
    check("t4_first7", 32'(first7), 32'h40);
    mism = 0;
    for (int i = 0; i < 256 - 127; i++) if (bits[i] != bits[i+127]) mism++;
    check("t4_period", 32'(mism), 32'h0);

    // Mode change mid-word takes effect at the next boundary; polarity swap.
    do_reset();
    for (int i = 0; i < 2; i++) begin
      bus_if.din = NIN'($urandom); bus_if.din_valid = 1'b1;
      step();
    end
    bus_if.din_valid = 1'b0;
    en = 1'b1; mode = 2'd0;
    repeat (2) step();
    mode = 2'd2; pat = 16'hA5A5;
    repeat (2) step();
    step();
    check("t5_pat_s0", 32'(bus_if.dout_p), 32'h5);
    repeat (3) step();
    inv_pol = 1'b1;
    step();
    check("t5_inv_s0", 32'(bus_if.dout_p), 32'hA);
    repeat (3) step();
    inv_pol = 1'b0;

    // Asynchronous reset mid-word with words queued.
    do_reset();
    mode = 2'd0;
    for (int i = 0; i < 4; i++) begin
      bus_if.din = NIN'($urandom); bus_if.din_valid = 1'b1;
      step();
    end
    bus_if.din_valid = 1'b0;
    en = 1'b1;
    repeat (2) step();
    #2;
    rstb = 1'b0;
    #1;
    check("t6_p", 32'(bus_if.dout_p), 32'h0);
    check("t6_n", 32'(bus_if.dout_n), 32'h0);
    check("t6_valid", 32'(bus_if.dout_valid), 32'h0);
    check("t6_level", 32'(fifo_level), 32'h0);
    check("t6_uf", 32'(underflow_cnt), 32'h0);
    do_reset();
    mode = 2'd1; en = 1'b1;
    repeat (8) step();

    // Random traffic, enables, modes and polarity.
    do_reset();
    for (int c = 0; c < 600; c++) begin
      en               = ($urandom_range(0, 9) != 0);
      bus_if.din_valid = $urandom_range(0, 1);
      bus_if.din       = NIN'($urandom);
      inv_pol          = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 7) == 0) mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 15) == 0) pat = NIN'($urandom);
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/tx_gearbox_mux.md
Name: tx_gearbox_mux

Overview:
Parametrised digital successor to the fixed 16:4 half-rate mux stage of the transmitter. It accepts Nin-bit parallel words over a valid/ready handshake and buffers them in a small word FIFO. Each word is serialised into Nin/Nout consecutive Nout-bit lane slices, and a differential pair (p/n) is driven to the quarter-rate 4:1 stage. Adds features the fixed mux lacks:
- on-chip PRBS7 and fixed-pattern modes;
- polarity inversion;
- an underflow counter;
- a clean enable/idle behaviour.

Parameters:
Nin, 16, input word width; must be an integer multiple of Nout.
Nout, 4, output lanes per cycle (quarter-rate lanes).
Depth, 4, FIFO depth in words; power of 2, at least 2.

Ports:
clk  input  1  gearbox clock, one slice per rising edge
rstb  input  1  asynchronous active-low reset
en  input  1  gearbox enable
mode  input  2  0=data, 1=PRBS7, 2=fixed pattern, 3=idle (zeros)
inv_pol  input  1  swap dout_p/dout_n
pat  input  Nin  fixed pattern word (mode 2)
din  input  Nin  data word
din_valid  input  1  din qualifier
din_ready  output  1  FIFO can accept a word
dout_p  output  Nout  lane slice, positive
dout_n  output  Nout  lane slice, negative
dout_valid  output  1  dout carries a live slice
fifo_level  output  $clog2(Depth)+1  words in FIFO
underflow_cnt  output  8  saturating data-mode underflow count

Behaviour:
- Ratio R = Nin/Nout. Slice counter cnt runs 0..R-1 and wraps to 0.
- All state resets asynchronously on rstb low:
  - dout_p=0, dout_n=0, dout_valid=0;
  - cnt=0, FIFO empty (fifo_level=0), underflow_cnt=0;
  - PRBS state=7'h7F, mode_q=3 (idle).
- din_ready = (fifo_level != Depth), combinational from level; it is 1 out of reset.
- Write occurs on an edge with din_valid & din_ready. Writes are independent of en.
- No fall-through: a word written at edge t is loadable at edge t+1 at the earliest.
- Load (edge with en=1 and cnt==0):
  - mode is sampled into mode_q; mode changes take effect only at word boundaries.
  - The source word W is selected by the new mode:
    - data: pop the FIFO head. If the FIFO is empty, W=0 and underflow_cnt increments, saturating at 255.
    - PRBS7: W = next Nin bits of the LFSR.
    - pattern: W = pat.
    - idle: W = 0.
  - W[Nin-1:Nout] goes into the shift register; dout gets W[Nout-1:0].
- Non-load edge with en=1: dout gets the next slice, i.e. W[cnt*Nout +: Nout]. Slice 0 is the lowest bits; bit order within a slice is unchanged.
- Output encoding: dout_p = slice ^ {Nout{inv_pol}}, dout_n = ~dout_p. Both are registered; inv_pol is sampled every cycle. dout_valid=1.
- en=0 at an edge:
  - cnt goes to 0; dout_p=0, dout_n=0, dout_valid=0.
  - FIFO, PRBS state and underflow_cnt are retained.
  - Re-enabling always starts on a word boundary (load on the first enabled edge).
- PRBS7:
  - Polynomial x^7+x^6+1, Fibonacci form.
  - Per step: out = s[6]^s[5]; s = {s[5:0], out}.
  - Word bit i (LSB first) is the i-th step output. The LFSR advances Nin steps per PRBS load only.
  - If the state is ever 0, reload 7'h7F at the next load.
- Simultaneous write and pop on the same edge: level is unchanged. A push when full cannot occur because ready is low.
- FIFO pointers wrap modulo Depth.
- Latency with en=1, cnt==0 and FIFO empty: word written at edge t is popped at the next boundary edge, t+R. First slice is visible after that edge.

Test Plan:
1. Nin=16, Nout=4, mode=0: push 16'h4321, then en=1 at a boundary. Required: dout_p = 1,2,3,4 on consecutive cycles, dout_n = E,D,C,B, dout_valid=1.
2. en=0, push 5 words back-to-back. Required: 4 accepted, fifo_level=4, din_ready=0 on the 5th; after en=1 the FIFO drains in order.
3. mode=0, en=1, FIFO empty for 8 cycles. Required: dout_p=0, underflow_cnt=2; after 300 empty boundaries, underflow_cnt=255 (saturated).
4. mode=1 after reset. Required: first 7 output bits 0,0,0,0,0,0,1 (seed 7F); the bitstream matches the golden LFSR and repeats every 127 bits.
5. mode=0 switched to 2 (pat=16'hA5A5) at cnt=2. Required: the current word finishes, the next word shows slices 5,A,5,A; inv_pol=1 gives dout_p=A,5,A,5.
6. rstb low at cnt=2 with 3 words queued. Required: outputs 0 immediately (asynchronous), fifo_level=0, underflow_cnt=0, PRBS restarts from 7'h7F.
